// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD-card constants for CMD-line CRC-7 and frame sizing
package sd_pkg;

    // CRC-7 for the CMD line: x^7 + x^3 + 1, seeded with zero
    localparam int          CRC7_W    = 7;
    localparam logic [6:0]  CRC7_POLY = 7'h09;
    localparam logic [6:0]  CRC7_INIT = 7'h00;

    // Command frame: start + dir + 6-bit index + 32-bit arg = 40 content bits,
    // followed by 7 CRC bits and the end bit
    localparam int CMD_FRAME_BITS   = 48;
    localparam int CMD_CONTENT_BITS = 40;

endpackage

// File: rtl/sd_crc7_gen.sv
// rtl/sd_crc7_gen.sv - serial CRC-7 generator/checker for the SD CMD line (optional checker: SD_CRC7_CHECK_EN)
module sd_crc7_gen
    import sd_pkg::*;
#(
    parameter int               CRC_W = CRC7_W,
    parameter logic [CRC_W-1:0] POLY  = CRC7_POLY,
    parameter logic [CRC_W-1:0] INIT  = CRC7_INIT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLEAR,
    input  logic             ENABLE,
    input  logic             BITVAL,
`ifdef SD_CRC7_CHECK_EN
    input  logic [CRC_W-1:0] EXP_CRC,
    input  logic             CHECK_STB,
    output logic             CRC_MATCH,
    output logic             CRC_ERR,
`endif
    output logic [CRC_W-1:0] CRC,
    output logic             CRC_ZERO
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;

    // One LFSR step: feedback is the incoming bit XOR the bit falling off the top
    function automatic logic [CRC_W-1:0] crc7_next(
        input logic [CRC_W-1:0] crc,
        input logic             bit_in
    );
        logic inv;
        inv = bit_in ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (inv ? POLY : '0);
    endfunction

    // Next CRC: clear beats shift; BITVAL only reaches the register when enabled
    always_comb begin
        crc_d = crc_q;
        if (CLEAR) begin
            crc_d = INIT;
        end else if (ENABLE) begin
            crc_d = crc7_next(crc_q, BITVAL);
        end
    end

    // CRC register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign CRC      = crc_q;
    assign CRC_ZERO = (crc_q == '0);

`ifdef SD_CRC7_CHECK_EN
    logic crc_err_q;
    logic crc_err_d;

    assign CRC_MATCH = (crc_q == EXP_CRC);

    // Sticky mismatch flag: cleared with the CRC, set by a failing strobe
    always_comb begin
        crc_err_d = crc_err_q;
        if (CLEAR) begin
            crc_err_d = 1'b0;
        end else if (CHECK_STB && !CRC_MATCH) begin
            crc_err_d = 1'b1;
        end
    end

    // Error flag register shares the CRC reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= crc_err_d;
        end
    end

    assign CRC_ERR = crc_err_q;
`endif

endmodule

// File: tb/tb_sd_crc7_gen.sv
// tb/tb_sd_crc7_gen.sv - scoreboard testbench for sd_crc7_gen against a polynomial-division model
module tb_sd_crc7_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       enable = 1'b0;
    logic       bitval = 1'b0;
    logic [6:0] crc;
    logic       crc_zero;
`ifdef SD_CRC7_CHECK_EN
    logic [6:0] exp_crc = 7'h00;
    logic       check_stb = 1'b0;
    logic       crc_match;
    logic       crc_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bit         hist[$];
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    sd_crc7_gen dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .CLEAR    (clear),
        .ENABLE   (enable),
        .BITVAL   (bitval),
`ifdef SD_CRC7_CHECK_EN
        .EXP_CRC  (exp_crc),
        .CHECK_STB(check_stb),
        .CRC_MATCH(crc_match),
        .CRC_ERR  (crc_err),
`endif
        .CRC      (crc),
        .CRC_ZERO (crc_zero)
    );

    // Remainder of (message * x^7) divided by x^7 + x^3 + 1 (0x89), by long division
    function automatic logic [6:0] ref_crc();
        int r = 0;
        int n = hist.size();
        for (int i = 0; i < n + 7; i++) begin
            r = (r << 1) | ((i < n) ? int'(hist[i]) : 0);
            if ((r & 'h80) != 0) r = r ^ 'h89;
        end
        return r[6:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one cycle of inputs, let the edge consume them, update the model
    task automatic step(input logic r, input logic c, input logic e, input logic b);
        rst_n  = r;
        clear  = c;
        enable = e;
        bitval = b;
        @(posedge clk);
        #1;
        if (!r || c) hist.delete();
        else if (e) hist.push_back(b);
        exp_q.push_back(ref_crc());
    endtask

    task automatic shift_bits(input logic [47:0] v, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) step(1'b1, 1'b0, 1'b0, 1'($urandom));
            end
            step(1'b1, 1'b0, 1'b1, v[i]);
        end
    endtask

    // Monitor: every registered result is compared on the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [6:0] e;
            e = exp_q.pop_front();
            check("sb_crc", 32'(crc), 32'(e));
            check("sb_crc_zero", 32'(crc_zero), 32'(e == 7'h00));
        end
    end

    initial begin
        // Reset held with enable and data active
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_crc", 32'(crc), 32'h00);
        check("reset_zero", 32'(crc_zero), 32'h1);

        // Known command CRCs
        shift_bits(48'h40_0000_0000, 40, 1'b0);
        check("cmd0", 32'(crc), 32'h4A);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        shift_bits(48'h51_0000_0000, 40, 1'b0);
        check("cmd17", 32'(crc), 32'h2A);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        shift_bits(48'h48_0000_01AA, 40, 1'b0);
        check("cmd8", 32'(crc), 32'h43);

        // Hold for 10 idle cycles with toggling data
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'(i));
        check("hold10", 32'(crc), 32'h43);

`ifdef SD_CRC7_CHECK_EN
        exp_crc = 7'h43;
        #1;
        check("match_43", 32'(crc_match), 32'h1);
        exp_crc = 7'h42;
        #1;
        check("match_42", 32'(crc_match), 32'h0);
        check_stb = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_stb = 1'b0;
        check("err_set", 32'(crc_err), 32'h1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom));
        check("err_sticky", 32'(crc_err), 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("err_clear", 32'(crc_err), 32'h0);
        shift_bits(48'h48_0000_01AA, 40, 1'b0);
`endif

        // Appending the CRC bits leaves a zero remainder
        shift_bits(48'h43, 7, 1'b0);
        check("selfcheck_crc", 32'(crc), 32'h00);
        check("selfcheck_zero", 32'(crc_zero), 32'h1);

        // CMD0 with random enable gaps and toggling data
        step(1'b1, 1'b1, 1'b0, 1'b0);
        shift_bits(48'h40_0000_0000, 40, 1'b1);
        check("cmd0_gaps", 32'(crc), 32'h4A);

        // Clear mid-frame wins over a simultaneous enabled bit
        step(1'b1, 1'b1, 1'b0, 1'b0);
        shift_bits(48'h51_00, 13, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("clear_prio", 32'(crc), 32'h00);
        shift_bits(48'h40_0000_0000, 40, 1'b0);
        check("cmd0_after_clear", 32'(crc), 32'h4A);

        // Reset mid-frame
        shift_bits(48'h5A3, 12, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_midframe", 32'(crc), 32'h00);

        // Random frames with random gaps, clears and resets
        for (int f = 0; f < 20; f++) begin
            int n = $urandom_range(1, 48);
            logic [47:0] v = {$urandom, $urandom};
            shift_bits(v, n, 1'($urandom));
            case ($urandom_range(0, 3))
                0: step(1'b1, 1'b1, 1'($urandom), 1'($urandom));
                1: step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                default: ;
            endcase
        end

        @(negedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
